muldiv_unit: RTL
================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the execute stage of the pipelined MIPS core. It implements `mult`, `multu`, `div` and `divu` over a fixed multi-cycle sequence and produces the 64-bit `{hi, lo}` pair consumed by the hi/lo special-register file. `busy` stalls dependent `mfhi`/`mflo` in the hazard unit. `abort` lets the pipeline cancel an operation issued down a flushed path.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the counter width is derived from it.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation select:
  - 00 = `mult` (signed)
  - 01 = `multu`
  - 10 = `div` (signed)
  - 11 = `divu`
- `srca`  in  32  rs operand: multiplicand or dividend.
- `srcb`  in  32  rt operand: multiplier or divisor.
- `abort`  in  1  cancels an in-flight operation.
- `busy`  out  1  high whenever state ≠ IDLE (combinational from state).
- `done`  out  1  registered one-cycle pulse marking a fresh result.
- `hi`  out  32  registered result:
  - product[63:32] for multiplies;
  - remainder for divides.
- `lo`  out  32  registered result:
  - product[31:0] for multiplies;
  - quotient for divides.
- `divzero`  out  1  registered; set with the result of a divide whose `srcb` = 0, cleared with any other result.

## Operation
- States are IDLE, CALC and FIX.
- **IDLE**, on `start`=1 and `abort`=0:
  - latch `op`;
  - latch magnitudes `|srca|` and `|srcb|` (signed ops take two's-complement absolute value; unsigned ops pass operands through);
  - record the sign flags:
    - `mult`: `neg_q = sa^sb`;
    - `div`: `neg_q = sa^sb` and `neg_r = sa`;
    - unsigned ops: both flags 0;
  - record `zdiv = (srcb == 0)` for divides;
  - clear the 64-bit accumulator, set counter = 0, go to CALC.
- **CALC**: one radix-2 step per cycle, exactly 32 cycles; counter increments and the state moves to FIX when counter = 31.
  - Multiply: shift-add over the accumulator.
  - Divide: restoring division. Shift {rem, quot} left by 1, trial-subtract the divisor from rem; if the result is non-negative, keep it and set quotient bit = 1.
- **FIX**: apply sign correction, write `hi`/`lo`/`divzero`, set `done`, return to IDLE.
  - Multiply: negate the 64-bit product if `neg_q`.
  - Divide: negate the quotient if `neg_q` and the remainder if `neg_r`.
  - Divide by zero overrides: `hi` = original `srca`, `lo` = 32'hFFFFFFFF, `divzero` = 1, for both signed and unsigned.
  - `div` 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0; no trap.
- `start` while busy is ignored; no queuing.
- `hi`/`lo`/`divzero` hold their values until the next FIX; they do not change in IDLE or CALC.
- **`abort`** in CALC or FIX:
  - next state is IDLE;
  - `hi`/`lo`/`divzero` are unchanged and `done` stays 0.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the request is dropped.
- **`reset`** has priority over everything, including mid-operation:
  - state = IDLE, counter = 0;
  - `hi` = `lo` = 0;
  - `done` = 0, `divzero` = 0.

## Timing
- `start` is accepted at rising edge k.
- `busy` is high in the cycles following edges k through k+32 (33 cycles).
- Edges k+1..k+32 are the CALC iterations; edge k+33 executes FIX.
- `hi`/`lo`/`divzero` are updated at edge k+33 and `done` = 1 after edge k+33.
- `done` returns to 0 at edge k+34 unless a new FIX occurs.
- `busy` = 0 in the `done` cycle. A `start` seen at edge k+34 is accepted, giving a back-to-back throughput of one operation per 34 cycles.
- Latency is fixed at 33 edges from acceptance to result for all ops and all data values; there is no early termination.
- `abort` sampled high at any edge while busy: `busy` = 0 after that edge.

## Test plan
- `multu` 0xFFFFFFFF × 0xFFFFFFFF, `start` at edge k -> `hi` = 0xFFFFFFFE, `lo` = 0x00000001, `done` pulses exactly once after edge k+33, `busy` high for 33 cycles.
- `mult` −3 × 7 -> `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- Signed and unsigned divides:
  - `div` −7 / 2 -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF;
  - `divu` 100 / 7 -> `lo` = 14, `hi` = 2.
- Edge-case divides:
  - `div` 0x12345678 / 0 -> `divzero` = 1, `hi` = 0x12345678, `lo` = 0xFFFFFFFF;
  - `div` 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0, `divzero` = 0.
- Control interactions:
  - a second `start` 5 cycles into an op is ignored, and the first op's result is unchanged;
  - `abort` in cycle 10 gives `busy` = 0 next cycle, no `done`, and `hi`/`lo` keep the prior result;
  - `reset` mid-CALC clears `hi`/`lo` to 0.
- Back-to-back: `start` held high continuously -> second op accepted in the `done` cycle; results of both ops are correct with 34-cycle spacing.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with a fixed 33-edge latency from acceptance to result.
// Produces {hi, lo} for mult/multu/div/divu. Abort cancels an operation; reset overrides abort.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                 state_q, state_d;
  logic                   is_div_q;
  logic [WIDTH-1:0]       a_q, b_q, srca_q;
  logic                   neg_q, neg_r_q, zdiv_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]       hi_q, lo_q;
  logic                   done_q, divzero_q;

  logic                   accept;
  logic                   sa, sb;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         rem_sh, diff;
  logic [2*WIDTH-1:0]     mul_step, div_step;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quot_fix, rem_fix;

  assign accept = (state_q == StIdle) && start && !abort;

  // Signed ops (op[0] == 0) work on magnitudes; sign is restored in FIX.
  always_comb begin
    sa    = ~op[0] & srca[WIDTH-1];
    sb    = ~op[0] & srcb[WIDTH-1];
    mag_a = sa ? -srca : srca;
    mag_b = sb ? -srcb : srcb;
  end

  // a_q shifts left each CALC cycle, so a_q[WIDTH-1] is the current operand bit (MSB first).
  always_comb begin
    mul_step = {acc_q[2*WIDTH-2:0], 1'b0} + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b_q};
    div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !abort) state_d = StCalc;
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      srca_q    <= '0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      zdiv_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        is_div_q <= op[1];
        a_q      <= mag_a;
        b_q      <= mag_b;
        srca_q   <= srca;
        neg_q    <= sa ^ sb;
        neg_r_q  <= op[1] & sa;
        zdiv_q   <= op[1] && (srcb == '0);
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == StCalc) begin
        acc_q <= is_div_q ? div_step : mul_step;
        a_q   <= a_q << 1;
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == StFix) && !abort) begin
        done_q    <= 1'b1;
        divzero_q <= zdiv_q;
        if (!is_div_q) begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end else if (zdiv_q) begin
          hi_q <= srca_q;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end
      end
    end
  end

  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;

endmodule
